// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, ROM address drive and IF/ID register.
// Redirects take priority over stalls, and stalls take priority over flushes.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] pc;
    logic [31:0] pc_next_seq;

    assign pc_next_seq = pc + PC_STEP;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            if_id_instr_o    <= NOP_INSTR;
            if_id_pc_o       <= '0;
            if_id_pc_plus4_o <= '0;
            if_id_valid_o    <= 1'b0;
            misalign_o       <= 1'b0;
            fetch_count_o    <= '0;
        end else if (redirect_valid_i) begin
            // Low address bits are dropped; a misaligned target is only flagged.
            pc            <= {redirect_pc_i[31:2], 2'b00};
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_o <= 1'b1;
            end
        end else if (stall_i) begin
            pc <= pc;
        end else if (flush_i) begin
            pc            <= pc_next_seq;
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
        end else begin
            pc               <= pc_next_seq;
            if_id_instr_o    <= imem_rdata_i;
            if_id_pc_o       <= pc;
            if_id_pc_plus4_o <= pc_next_seq;
            if_id_valid_o    <= 1'b1;
            if (fetch_count_o != 32'hFFFF_FFFF) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
        end
    end

endmodule
